// File: rtl/rv32_pkg.sv
// Shared RV32 decode types: opcode/funct3 aliases, instruction format class
// and the opcode constants recognised by the decode stage.
package rv32_pkg;

  typedef logic [6:0] opcode_t;
  typedef logic [2:0] funct3_t;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam opcode_t OPC_LOAD     = 7'b0000011;
  localparam opcode_t OPC_MISC_MEM = 7'b0001111;
  localparam opcode_t OPC_OP_IMM   = 7'b0010011;
  localparam opcode_t OPC_AUIPC    = 7'b0010111;
  localparam opcode_t OPC_STORE    = 7'b0100011;
  localparam opcode_t OPC_OP       = 7'b0110011;
  localparam opcode_t OPC_LUI      = 7'b0110111;
  localparam opcode_t OPC_BRANCH   = 7'b1100011;
  localparam opcode_t OPC_JALR     = 7'b1100111;
  localparam opcode_t OPC_JAL      = 7'b1101111;
  localparam opcode_t OPC_SYSTEM   = 7'b1110011;
  localparam opcode_t OPC_OP_P     = 7'b1110111;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational format classifier and immediate generator for one RV32 word.
// Define RV32P_EN to accept the packed-SIMD OP-P opcode as an R-format instruction.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] inst,
  output fmt_t        fmt,
  output logic [31:0] imm,
  output logic        illegal
);

  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    case (opcode_t'(inst[6:0]))
      OPC_OP:                                                fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE:                                             fmt = FMT_S;
      OPC_BRANCH:                                            fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                                    fmt = FMT_U;
      OPC_JAL:                                               fmt = FMT_J;
`ifdef RV32P_EN
      OPC_OP_P:                                              fmt = FMT_R;
`endif
      // Any encoding with inst[1:0] != 2'b11 also lands here, since it cannot match.
      default:                                               illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = 32'd0;
    case (fmt)
      FMT_I: imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm = {inst[31:12], 12'd0};
      FMT_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Buffered RV32 decode stage: DEPTH-entry {inst, pc} FIFO with flush, decoding
// the head entry combinationally. RV32P_EN (see imm_gen) enables the OP-P opcode.
module decode_stage
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output opcode_t         out_opcode,
  output logic [4:0]      out_rd,
  output funct3_t         out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output fmt_t            out_fmt,
  output logic [31:0]     out_imm,
  output logic            out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop;
  logic [31:0]      head_inst;

  // in_ready comes straight from the count register, so a full FIFO refuses a
  // push even when the head is popped in the same cycle.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (push && !flush) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign head_inst  = inst_mem[rd_ptr];
  assign out_pc     = pc_mem[rd_ptr];
  assign out_opcode = head_inst[6:0];
  assign out_rd     = head_inst[11:7];
  assign out_funct3 = head_inst[14:12];
  assign out_rs1    = head_inst[19:15];
  assign out_rs2    = head_inst[24:20];
  assign out_funct7 = head_inst[31:25];

  imm_gen u_imm_gen (
    .inst    (head_inst),
    .fmt     (out_fmt),
    .imm     (out_imm),
    .illegal (out_illegal)
  );

endmodule
